// File: rtl/writeback_queue.sv
// writeback_queue
// Small circular buffer that sits in front of the register file write port.
// It accepts up to two results per cycle, with the Mem result ahead of the ALU
// result, and retires one entry per cycle into Awr/Din/WrEn. Entries that are
// still pending are searched against the two read addresses so that the
// youngest pending value can be forwarded. Stall is raised once fewer than two
// free slots remain. Any push attempted while stalled is dropped and recorded
// in the sticky Overflow flag.

module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         MemVld,
    input  logic [AW-1:0]                MemAddr,
    input  logic [DW-1:0]                MemData,
    input  logic                         AluVld,
    input  logic [AW-1:0]                AluAddr,
    input  logic [DW-1:0]                AluData,
    input  logic [AW-1:0]                Ard1,
    input  logic [AW-1:0]                Ard2,
    output logic [AW-1:0]                Awr,
    output logic [DW-1:0]                Din,
    output logic                         WrEn,
    output logic                         Fwd1Hit,
    output logic [DW-1:0]                Fwd1Data,
    output logic                         Fwd2Hit,
    output logic [DW-1:0]                Fwd2Data,
    output logic                         Stall,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Storage is not reset. Only the pointers and the count decide which slots
    // are meaningful.
    logic [AW-1:0] addrMem_q [DEPTH];
    logic [DW-1:0] dataMem_q [DEPTH];

    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          memReq, aluReq;
    logic          memPush, aluPush;
    logic          pop;
    logic          stallInt;
    logic [PW-1:0] aluSlot;

    // Register 0 writes are meaningless, so they never count as a request.
    assign memReq   = MemVld && (MemAddr != '0);
    assign aluReq   = AluVld && (AluAddr != '0);

    // Keep two slots in reserve so that a Mem/ALU pair always fits when not stalled.
    assign stallInt = (count_q >= CW'(DEPTH-1));
    assign memPush  = memReq && !stallInt;
    assign aluPush  = aluReq && !stallInt;
    assign pop      = (count_q != '0);

    // The ALU entry goes in the slot after the Mem entry when both are pushed.
    assign aluSlot  = wrPtr_q + PW'(memPush);

    assign Stall    = stallInt;
    assign Count    = count_q;
    assign Overflow = overflow_q;
    assign WrEn     = pop;
    assign Awr      = pop ? addrMem_q[rdPtr_q] : '0;
    assign Din      = pop ? dataMem_q[rdPtr_q] : '0;

    // Next-state computation for the pointers, the occupancy and the sticky error flag.
    always_comb begin
        rdPtr_d    = rdPtr_q + PW'(pop);
        wrPtr_d    = wrPtr_q + PW'(memPush) + PW'(aluPush);
        count_d    = count_q + CW'(memPush) + CW'(aluPush) - CW'(pop);
        overflow_d = overflow_q | (stallInt & (memReq | aluReq));
    end

    // Control state. Asynchronous reset empties the queue at once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Write accepted entries into free slots. These never alias the head being popped.
    always_ff @(posedge Clk) begin
        if (memPush) begin
            addrMem_q[wrPtr_q] <= MemAddr;
            dataMem_q[wrPtr_q] <= MemData;
        end
        if (aluPush) begin
            addrMem_q[aluSlot] <= AluAddr;
            dataMem_q[aluSlot] <= AluData;
        end
    end

    // Scan the occupied slots from oldest to youngest so that the last match (the youngest) wins.
    always_comb begin
        logic [PW-1:0] slot;
        slot     = rdPtr_q;
        Fwd1Hit  = 1'b0;
        Fwd1Data = '0;
        Fwd2Hit  = 1'b0;
        Fwd2Data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rdPtr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((Ard1 != '0) && (addrMem_q[slot] == Ard1)) begin
                    Fwd1Hit  = 1'b1;
                    Fwd1Data = dataMem_q[slot];
                end
                if ((Ard2 != '0) && (addrMem_q[slot] == Ard2)) begin
                    Fwd2Hit  = 1'b1;
                    Fwd2Data = dataMem_q[slot];
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue
// Drives directed and random traffic into writeback_queue. Each cycle, the
// outputs are compared with a queue-based reference model of pending writes.

module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic          Clk;
    logic          Rst_n;
    logic          MemVld, AluVld;
    logic [AW-1:0] MemAddr, AluAddr, Ard1, Ard2;
    logic [DW-1:0] MemData, AluData;
    logic [AW-1:0] Awr;
    logic [DW-1:0] Din, Fwd1Data, Fwd2Data;
    logic          WrEn, Fwd1Hit, Fwd2Hit, Stall, Overflow;
    logic [$clog2(DEPTH+1)-1:0] Count;

    entry_t modelQ[$];
    logic   modelOvf;
    int     checkCount;
    int     passCount;
    int     drained;

    writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .MemVld(MemVld), .MemAddr(MemAddr), .MemData(MemData),
        .AluVld(AluVld), .AluAddr(AluAddr), .AluData(AluData),
        .Ard1(Ard1), .Ard2(Ard2),
        .Awr(Awr), .Din(Din), .WrEn(WrEn),
        .Fwd1Hit(Fwd1Hit), .Fwd1Data(Fwd1Data),
        .Fwd2Hit(Fwd2Hit), .Fwd2Data(Fwd2Data),
        .Stall(Stall), .Count(Count), .Overflow(Overflow)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    endtask

    // Search the pending writes from youngest to oldest.
    function automatic void modelFwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            for (int i = modelQ.size() - 1; i >= 0; i--) begin
                if (modelQ[i].addr == a) begin
                    hit = 1'b1;
                    d   = modelQ[i].data;
                    break;
                end
            end
        end
    endfunction

    // Compare every output with the values the model predicts.
    task automatic compareAll();
        logic          h1, h2;
        logic [DW-1:0] d1, d2;
        int            n;
        n = modelQ.size();
        modelFwd(Ard1, h1, d1);
        modelFwd(Ard2, h2, d2);
        checkOutput("wren",     32'(WrEn),     32'(n != 0));
        checkOutput("awr",      32'(Awr),      (n != 0) ? 32'(modelQ[0].addr) : 32'd0);
        checkOutput("din",      Din,           (n != 0) ? modelQ[0].data : 32'd0);
        checkOutput("count",    32'(Count),    n);
        checkOutput("stall",    32'(Stall),    32'(n >= DEPTH - 1));
        checkOutput("ovf",      32'(Overflow), 32'(modelOvf));
        checkOutput("fwd1hit",  32'(Fwd1Hit),  32'(h1));
        checkOutput("fwd1data", Fwd1Data,      d1);
        checkOutput("fwd2hit",  32'(Fwd2Hit),  32'(h2));
        checkOutput("fwd2data", Fwd2Data,      d2);
    endtask

    // Apply one edge to the model: retire the head, then accept Mem before ALU unless stalled.
    task automatic updateModel();
        bit stalled;
        stalled = (modelQ.size() >= DEPTH - 1);
        if (modelQ.size() != 0) void'(modelQ.pop_front());
        if (MemVld && MemAddr != 0) begin
            if (stalled) modelOvf = 1'b1;
            else modelQ.push_back('{MemAddr, MemData});
        end
        if (AluVld && AluAddr != 0) begin
            if (stalled) modelOvf = 1'b1;
            else modelQ.push_back('{AluAddr, AluData});
        end
    endtask

    // One cycle: drive the inputs at the negedge, check, clock, and advance the model.
    task automatic applyStimulus(input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                                 input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        MemVld = mv; MemAddr = ma; MemData = md;
        AluVld = av; AluAddr = aa; AluData = ad;
        Ard1 = a1; Ard2 = a2;
        #1;
        compareAll();
        @(posedge Clk);
        updateModel();
        @(negedge Clk);
    endtask

    // Run one cycle with no push requests.
    task automatic applyIdle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, a1, a2);
    endtask

    // Main sequence: directed scenarios followed by random traffic.
    initial begin
        checkCount = 0;
        passCount  = 0;
        modelOvf   = 1'b0;
        Rst_n = 1'b1;
        MemVld = 0; MemAddr = 0; MemData = 0;
        AluVld = 0; AluAddr = 0; AluData = 0;
        Ard1 = 0; Ard2 = 0;
        #2 Rst_n = 1'b0;
        @(negedge Clk);
        #1 compareAll();
        Rst_n = 1'b1;
        @(negedge Clk);

        // Single push.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'd1, 5'd0, 5'd0);
        checkOutput("single_wren", 32'(WrEn), 32'd1);
        checkOutput("single_awr",  32'(Awr),  32'd1);
        checkOutput("single_din",  Din,       32'd1);
        applyIdle(5'd0, 5'd0);
        checkOutput("single_done", 32'(WrEn), 32'd0);
        checkOutput("single_cnt",  32'(Count), 32'd0);

        // Mem and ALU writes to the same register in one cycle.
        applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd2, 32'h3, 5'd2, 5'd0);
        checkOutput("same_din0",  Din,              32'h2);
        checkOutput("same_fwd0",  Fwd1Data,         32'h3);
        checkOutput("same_hit0",  32'(Fwd1Hit),     32'd1);
        applyIdle(5'd2, 5'd0);
        checkOutput("same_din1",  Din,              32'h3);
        checkOutput("same_fwd1",  Fwd1Data,         32'h3);
        applyIdle(5'd0, 5'd0);

        // Writes to register 0 are ignored.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hABCD, 5'd0, 5'd0);
        checkOutput("r0_count", 32'(Count),    32'd0);
        checkOutput("r0_wren",  32'(WrEn),     32'd0);
        checkOutput("r0_ovf",   32'(Overflow), 32'd0);
        checkOutput("r0_hit",   32'(Fwd1Hit),  32'd0);

        // Fill until stalled, then push while stalled.
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd0, 5'd0);
        checkOutput("fill_cnt2",   32'(Count), 32'd2);
        checkOutput("fill_stall2", 32'(Stall), 32'd0);
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
        checkOutput("fill_cnt3",   32'(Count), 32'd3);
        checkOutput("fill_stall3", 32'(Stall), 32'd1);
        drained = 0;
        if (WrEn) drained++;
        applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
        checkOutput("fill_ovf", 32'(Overflow), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (!WrEn) break;
            drained++;
            applyIdle(5'd0, 5'd0);
        end
        checkOutput("drain_n",   drained,       32'd3);
        checkOutput("drain_ovf", 32'(Overflow), 32'd1);

        // The youngest pending write to a register is forwarded.
        applyStimulus(1'b1, 5'd7, 32'h7, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd31);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'h5, 5'd0, 5'd31);
        checkOutput("young_hit",  32'(Fwd2Hit), 32'd1);
        checkOutput("young_data", Fwd2Data,     32'h5);
        applyIdle(5'd0, 5'd31);
        applyIdle(5'd0, 5'd31);
        checkOutput("young_gone", 32'(Fwd2Hit), 32'd0);

        // Reset asserted mid-operation.
        applyStimulus(1'b1, 5'd8, 32'h8, 1'b1, 5'd9, 32'h9, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA, 5'd0, 5'd0);
        MemVld = 0; AluVld = 0;
        #2 Rst_n = 1'b0;
        modelQ.delete();
        modelOvf = 1'b0;
        #1;
        checkOutput("rst_wren",  32'(WrEn),  32'd0);
        checkOutput("rst_count", 32'(Count), 32'd0);
        checkOutput("rst_stall", 32'(Stall), 32'd0);
        compareAll();
        @(posedge Clk);
        #1 checkOutput("rst_nowrite", 32'(WrEn), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Random traffic over a small address range so that forwarding matches are frequent.
        for (int n = 0; n < 400; n++) begin
            logic          mv, av;
            logic [AW-1:0] ma, aa, a1, a2;
            logic [DW-1:0] md, ad;
            mv = 1'($urandom_range(0, 1));
            av = 1'($urandom_range(0, 1));
            ma = AW'($urandom_range(0, 7));
            aa = AW'($urandom_range(0, 7));
            a1 = AW'($urandom_range(0, 7));
            a2 = AW'($urandom_range(0, 7));
            md = $urandom;
            ad = $urandom;
            if ((n % 40) < 15) begin
                mv = 1'b0;
                if (n % 3 == 0) av = 1'b0;
            end
            applyStimulus(mv, ma, md, av, aa, ad, a1, a2);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
